// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pixel coordinate / DE inputs and registered RGB / status outputs
// of the test-pattern generator. The master drives pixels, the slave is the generator.
interface vga_pattern_gen_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 4,
    parameter int FRAME_W = 8
);
    logic [COORD_W-1:0] x_pixel;
    logic [COORD_W-1:0] y_pixel;
    logic               DE;
    logic [1:0]         mode;
    logic [COLOR_W-1:0] red_port;
    logic [COLOR_W-1:0] green_port;
    logic [COLOR_W-1:0] blue_port;
    logic               de_out;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output x_pixel, y_pixel, DE, mode,
        input  red_port, green_port, blue_port, de_out, frame_cnt
    );

    modport slave (
        input  x_pixel, y_pixel, DE, mode,
        output red_port, green_port, blue_port, de_out, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: registered four-mode VGA test-pattern generator, 1-clk latency.
// Optional white border overlay is enabled by defining VGA_PATTERN_BORDER_EN.
module vga_pattern_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 10,
    parameter int COLOR_W      = 4,
    parameter int NUM_BARS     = 7,
    parameter int CHECKER_LOG2 = 5,
    parameter int SCROLL_STEP  = 4,
    parameter int FRAME_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    vga_pattern_gen_if.slave bus
);
    localparam int BAR_W  = ((H_ACTIVE / NUM_BARS) > 0) ? (H_ACTIVE / NUM_BARS) : 1;
    localparam int RAMP_W = ((H_ACTIVE >> COLOR_W) > 0) ? (H_ACTIVE >> COLOR_W) : 1;
    localparam int CW1    = COORD_W + 1;
    localparam logic [COLOR_W-1:0] MAX = '1;

    logic [COORD_W-1:0] x, y;
    logic               de, frame_start, frame_end, line_start;
    logic [1:0]         mode_sel, mode_act_q, mode_act_d;
    logic [COORD_W-1:0] pos_q, pos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [COORD_W-1:0] bar_px_q, bar_px_d, bar_px_cur;
    logic [2:0]         bar_idx_q, bar_idx_d, bar_idx_cur;
    logic [COORD_W-1:0] ramp_px_q, ramp_px_d, ramp_px_cur;
    logic [COLOR_W-1:0] ramp_lvl_q, ramp_lvl_d, ramp_lvl_cur;
    logic [CW1-1:0]     x_ext, pos_ext, bar_hi, pos_sum;
    logic               scroll_on, checker_on;
    logic [2:0]         bar_bits;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               de_q;

    assign x           = bus.x_pixel;
    assign y           = bus.y_pixel;
    assign de          = bus.DE;
    assign frame_start = de && (x == '0) && (y == '0);
    assign frame_end   = de && (x == COORD_W'(H_ACTIVE - 1)) && (y == COORD_W'(V_ACTIVE - 1));
    assign line_start  = (x == '0);
    // The frame-start pixel itself already renders in the newly requested mode.
    assign mode_sel    = frame_start ? bus.mode : mode_act_q;
    assign mode_act_d  = mode_sel;
    assign x_ext       = {1'b0, x};
    assign pos_ext     = {1'b0, pos_q};
    assign pos_sum     = pos_ext + CW1'(SCROLL_STEP);
    assign bar_hi      = pos_ext + CW1'(BAR_W);

    always_comb begin
        frame_d = frame_q;
        pos_d   = pos_q;
        if (frame_end) begin
            frame_d = frame_q + FRAME_W'(1);
            pos_d   = (pos_sum >= CW1'(H_ACTIVE)) ? COORD_W'(pos_sum - CW1'(H_ACTIVE))
                                                  : pos_sum[COORD_W-1:0];
        end
    end

    // Pixel and index counters replace x/BAR_W and x/RAMP_W; column 0 restarts them.
    always_comb begin
        bar_px_cur   = line_start ? '0 : bar_px_q;
        bar_idx_cur  = line_start ? '0 : bar_idx_q;
        ramp_px_cur  = line_start ? '0 : ramp_px_q;
        ramp_lvl_cur = line_start ? '0 : ramp_lvl_q;
        bar_px_d     = bar_px_q;
        bar_idx_d    = bar_idx_q;
        ramp_px_d    = ramp_px_q;
        ramp_lvl_d   = ramp_lvl_q;
        if (de) begin
            if (bar_px_cur == COORD_W'(BAR_W - 1)) begin
                bar_px_d  = '0;
                bar_idx_d = (bar_idx_cur == 3'(NUM_BARS - 1)) ? bar_idx_cur : bar_idx_cur + 3'd1;
            end else begin
                bar_px_d  = bar_px_cur + COORD_W'(1);
                bar_idx_d = bar_idx_cur;
            end
            if (ramp_px_cur == COORD_W'(RAMP_W - 1)) begin
                ramp_px_d  = '0;
                ramp_lvl_d = (ramp_lvl_cur == MAX) ? ramp_lvl_cur : ramp_lvl_cur + COLOR_W'(1);
            end else begin
                ramp_px_d  = ramp_px_cur + COORD_W'(1);
                ramp_lvl_d = ramp_lvl_cur;
            end
        end
    end

    always_comb begin
        scroll_on  = ((x_ext >= pos_ext) && (x_ext < bar_hi)) ||
                     ((bar_hi > CW1'(H_ACTIVE)) && (x_ext < (bar_hi - CW1'(H_ACTIVE))));
        checker_on = ~(x[CHECKER_LOG2] ^ y[CHECKER_LOG2]);
        case (bar_idx_cur)
            3'd0:    bar_bits = 3'b111;
            3'd1:    bar_bits = 3'b110;
            3'd2:    bar_bits = 3'b011;
            3'd3:    bar_bits = 3'b010;
            3'd4:    bar_bits = 3'b101;
            3'd5:    bar_bits = 3'b100;
            3'd6:    bar_bits = 3'b001;
            default: bar_bits = 3'b000;
        endcase
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (de) begin
            case (mode_sel)
                2'd0: begin
                    red_d   = {COLOR_W{bar_bits[2]}};
                    green_d = {COLOR_W{bar_bits[1]}};
                    blue_d  = {COLOR_W{bar_bits[0]}};
                end
                2'd1: begin
                    red_d   = {COLOR_W{checker_on}};
                    green_d = {COLOR_W{checker_on}};
                    blue_d  = {COLOR_W{checker_on}};
                end
                2'd2: begin
                    red_d   = ramp_lvl_cur;
                    green_d = ramp_lvl_cur;
                    blue_d  = ramp_lvl_cur;
                end
                default: begin
                    red_d   = {COLOR_W{scroll_on}};
                    green_d = {COLOR_W{scroll_on}};
                    blue_d  = {COLOR_W{scroll_on}};
                end
            endcase
`ifdef VGA_PATTERN_BORDER_EN
            if ((x == '0) || (x == COORD_W'(H_ACTIVE - 1)) ||
                (y == '0) || (y == COORD_W'(V_ACTIVE - 1))) begin
                red_d   = MAX;
                green_d = MAX;
                blue_d  = MAX;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_act_q <= '0;
            pos_q      <= '0;
            frame_q    <= '0;
            bar_px_q   <= '0;
            bar_idx_q  <= '0;
            ramp_px_q  <= '0;
            ramp_lvl_q <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            de_q       <= 1'b0;
        end else begin
            mode_act_q <= mode_act_d;
            pos_q      <= pos_d;
            frame_q    <= frame_d;
            bar_px_q   <= bar_px_d;
            bar_idx_q  <= bar_idx_d;
            ramp_px_q  <= ramp_px_d;
            ramp_lvl_q <= ramp_lvl_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            de_q       <= de;
        end
    end

    assign bus.red_port   = red_q;
    assign bus.green_port = green_q;
    assign bus.blue_port  = blue_q;
    assign bus.de_out     = de_q;
    assign bus.frame_cnt  = frame_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed pixel stimulus for vga_pattern_gen, checked every cycle
// against an arithmetic reference model plus hand-computed literal expectations.
module tb_vga_pattern_gen;
    localparam int H    = 640;
    localparam int V    = 480;
    localparam int BW   = H / 7;
    localparam int RW   = H >> 4;
    localparam int STEP = 4;
`ifdef VGA_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_pattern_gen_if bus ();
    vga_pattern_gen dut (.clk(clk), .reset(rst), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] last_rgb;
    logic        last_de;
    logic [7:0]  last_fc;
    logic [11:0] lrgb [H];
    logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int          k_m, mact_m, sx, sy;
    bit          started = 1'b0;
    logic [11:0] e_rgb;
    logic        e_de;

    function automatic logic [11:0] edge_white(int x, int y, logic [11:0] c);
        return (BORDER && (x == 0 || x == H - 1 || y == 0 || y == V - 1)) ? 12'hFFF : c;
    endfunction

    function automatic logic [11:0] model_rgb(int x, int y, int m, int pos);
        logic [11:0] c;
        int b;
        case (m)
            0: begin
                b = x / BW;
                if (b > 6) b = 6;
                c = BARS[b];
            end
            1: c = ((((x / 32) + (y / 32)) % 2) == 0) ? 12'hFFF : 12'h000;
            2: begin
                b = x / RW;
                if (b > 15) b = 15;
                c = {3{4'(b)}};
            end
            default: c = ((x >= pos && x < pos + BW) || (x < pos + BW - H)) ? 12'hFFF : 12'h000;
        endcase
        return edge_white(x, y, c);
    endfunction

    // Reference model: evaluated on the inputs present at each edge, checked 1 time unit later.
    always @(posedge clk) begin
        if (rst) begin
            k_m     = 0;
            mact_m  = 0;
            e_rgb   = 12'h000;
            e_de    = 1'b0;
            started = 1'b1;
        end else begin
            sx = int'(bus.x_pixel);
            sy = int'(bus.y_pixel);
            if (bus.DE && sx == 0 && sy == 0) mact_m = int'(bus.mode);
            e_rgb = bus.DE ? model_rgb(sx, sy, mact_m, (k_m * STEP) % H) : 12'h000;
            e_de  = bus.DE;
            if (bus.DE && sx == H - 1 && sy == V - 1) k_m++;
        end
        #1;
        if (started) begin
            checks++;
            if ({bus.red_port, bus.green_port, bus.blue_port} !== e_rgb) begin
                failures++;
                $display("FAIL cyc_rgb x=%0d y=%0d got=%h exp=%h", sx, sy,
                         {bus.red_port, bus.green_port, bus.blue_port}, e_rgb);
            end
            checks++;
            if (bus.de_out !== e_de) begin
                failures++;
                $display("FAIL cyc_de x=%0d y=%0d got=%b exp=%b", sx, sy, bus.de_out, e_de);
            end
            checks++;
            if (bus.frame_cnt !== 8'(k_m)) begin
                failures++;
                $display("FAIL cyc_frame_cnt got=%0d exp=%0d", bus.frame_cnt, 8'(k_m));
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic px(input int x, input int y, input logic de, input int m);
        @(negedge clk);
        bus.x_pixel = 10'(x);
        bus.y_pixel = 10'(y);
        bus.DE      = de;
        bus.mode    = 2'(m);
        @(posedge clk);
        #2;
        last_rgb = {bus.red_port, bus.green_port, bus.blue_port};
        last_de  = bus.de_out;
        last_fc  = bus.frame_cnt;
    endtask

    task automatic line(input int y, input int m0, input int m1, input int sw);
        for (int x = 0; x < H; x++) begin
            px(x, y, 1'b1, (x >= sw) ? m1 : m0);
            lrgb[x] = last_rgb;
        end
        px(0, y, 1'b0, m1);
        lit("de_low_rgb", last_rgb, 12'h000);
        lit("de_low_de", last_de, 1'b0);
    endtask

    task automatic qframe();
        px(0, 0, 1'b1, 3);
        px(H - 1, V - 1, 1'b1, 3);
    endtask

    initial begin
        rst         = 1'b1;
        bus.x_pixel = '0;
        bus.y_pixel = '0;
        bus.DE      = 1'b0;
        bus.mode    = '0;
        px(0, 0, 1'b0, 0);
        px(0, 0, 1'b0, 0);
        rst = 1'b0;

        // reset held three clocks in the middle of an active line
        for (int x = 0; x < 20; x++) px(x, 0, 1'b1, 0);
        rst = 1'b1;
        px(20, 0, 1'b1, 0);
        lit("rst_rgb", last_rgb, 12'h000);
        lit("rst_de", last_de, 1'b0);
        lit("rst_fc", last_fc, 8'd0);
        px(21, 0, 1'b1, 0);
        px(22, 0, 1'b1, 0);
        rst = 1'b0;
        for (int x = 23; x < 31; x++) px(x, 0, 1'b1, 0);
        lit("post_rst_bar0", last_rgb, 12'hFFF);
        lit("post_rst_de", last_de, 1'b1);
        px(0, 0, 1'b0, 0);

        // colour bars
        line(0, 0, 0, H);
        lit("bar_x0", lrgb[0], edge_white(0, 0, 12'hFFF));
        lit("bar_x90", lrgb[90], 12'hFFF);
        lit("bar_x91", lrgb[91], edge_white(91, 0, 12'hFF0));
        lit("bar_x545", lrgb[545], edge_white(545, 0, 12'hF00));
        lit("bar_x546", lrgb[546], edge_white(546, 0, 12'h00F));
        lit("bar_x639", lrgb[639], edge_white(639, 0, 12'h00F));

        // mode request changes mid-frame: frame stays bars
        line(100, 0, 1, 200);
        lit("switch_x199", lrgb[199], 12'h0FF);
        lit("switch_x250", lrgb[250], 12'h0FF);
        px(H - 1, V - 1, 1'b1, 1);
        lit("fc_after_1", last_fc, 8'd1);

        // checkerboard takes effect at next frame start
        line(0, 1, 1, 0);
        lit("chk_0_0", lrgb[0], 12'hFFF);
        lit("chk_32_0", lrgb[32], edge_white(32, 0, 12'h000));
        lit("chk_64_0", lrgb[64], 12'hFFF);
        line(32, 1, 1, 0);
        lit("chk_32_32", lrgb[32], 12'hFFF);
        lit("chk_1_32", lrgb[1], 12'h000);
        lit("chk_63_32", lrgb[63], 12'hFFF);
        lit("chk_64_32", lrgb[64], 12'h000);
        px(H - 1, V - 1, 1'b1, 1);

        // grey ramp
        line(0, 2, 2, 0);
        lit("ramp_x0", lrgb[0], edge_white(0, 0, 12'h000));
        lit("ramp_x639", lrgb[639], 12'hFFF);
        line(1, 2, 2, 0);
        lit("ramp_r1_x1", lrgb[1], 12'h000);
        lit("ramp_r1_x40", lrgb[40], 12'h111);
        lit("ramp_r1_x79", lrgb[79], 12'h111);
        lit("ramp_r1_x80", lrgb[80], 12'h222);
        lit("ramp_r1_x639", lrgb[639], edge_white(639, 1, 12'hFFF));
        px(H - 1, V - 1, 1'b1, 2);

        // scrolling bar from a fresh reset
        rst = 1'b1;
        px(0, 0, 1'b0, 0);
        rst = 1'b0;
        px(0, 0, 1'b1, 3);
        line(1, 3, 3, 0);
        lit("scr0_x0", lrgb[0], edge_white(0, 1, 12'hFFF));
        lit("scr0_x90", lrgb[90], 12'hFFF);
        lit("scr0_x91", lrgb[91], 12'h000);
        px(H - 1, V - 1, 1'b1, 3);
        px(0, 0, 1'b1, 3);
        line(1, 3, 3, 0);
        lit("scr1_x3", lrgb[3], 12'h000);
        lit("scr1_x4", lrgb[4], 12'hFFF);
        lit("scr1_x94", lrgb[94], 12'hFFF);
        lit("scr1_x95", lrgb[95], 12'h000);
        px(H - 1, V - 1, 1'b1, 3);
        repeat (148) qframe();
        lit("fc_150", last_fc, 8'd150);
        px(0, 0, 1'b1, 3);
        line(1, 3, 3, 0);
        lit("scr600_x599", lrgb[599], 12'h000);
        lit("scr600_x600", lrgb[600], 12'hFFF);
        lit("scr600_x639", lrgb[639], 12'hFFF);
        lit("scr600_x0", lrgb[0], 12'hFFF);
        lit("scr600_x50", lrgb[50], 12'hFFF);
        lit("scr600_x51", lrgb[51], 12'h000);
        px(H - 1, V - 1, 1'b1, 3);
        repeat (9) qframe();
        lit("fc_160", last_fc, 8'd160);
        px(0, 0, 1'b1, 3);
        line(1, 3, 3, 0);
        lit("scr160_x0", lrgb[0], edge_white(0, 1, 12'hFFF));
        lit("scr160_x90", lrgb[90], 12'hFFF);
        lit("scr160_x91", lrgb[91], 12'h000);
        lit("scr160_x639", lrgb[639], edge_white(639, 1, 12'h000));
        px(H - 1, V - 1, 1'b1, 3);
        repeat (94) qframe();
        lit("fc_255", last_fc, 8'd255);
        qframe();
        lit("fc_wrap", last_fc, 8'd0);

        // edge pixels in scroll mode, bar at 384..474
        px(0, 0, 1'b1, 3);
        px(0, 240, 1'b1, 3);
        lit("edge_0_240", last_rgb, edge_white(0, 240, 12'h000));
        px(639, 240, 1'b1, 3);
        lit("edge_639_240", last_rgb, edge_white(639, 240, 12'h000));
        px(320, 0, 1'b1, 3);
        lit("edge_320_0", last_rgb, edge_white(320, 0, 12'h000));
        px(320, 479, 1'b1, 3);
        lit("edge_320_479", last_rgb, edge_white(320, 479, 12'h000));
        px(1, 1, 1'b1, 3);
        lit("edge_1_1", last_rgb, 12'h000);
        px(400, 1, 1'b1, 3);
        lit("scr384_x400", last_rgb, 12'hFFF);
        px(0, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
